// File: rtl/fir_mac_sched_if.sv
// rtl/fir_mac_sched_if.sv - sample-in / filtered-sample-out handshake bundle for fir_mac_sched
interface fir_mac_sched_if #(
    parameter int NB_DATA  = 8,
    parameter int NB_COEFF = 8,
    parameter int NTAP     = 6,
    parameter int NB_OUT   = 8
) ();
    logic                     i_valid;
    logic                     o_ready;
    logic [NB_DATA-1:0]       i_data;
    logic [NTAP*NB_COEFF-1:0] i_coeff;
    logic                     o_valid;
    logic                     i_ready;
    logic [NB_OUT-1:0]        o_data;
    logic                     o_sat;
    logic                     o_busy;

    modport slave (
        input  i_valid, i_data, i_coeff, i_ready,
        output o_ready, o_valid, o_data, o_sat, o_busy
    );

    modport master (
        output i_valid, i_data, i_coeff, i_ready,
        input  o_ready, o_valid, o_data, o_sat, o_busy
    );
endinterface

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - serial FIR, one multiplier/accumulator shared across NTAP taps
// FIR_SCHED_ROUND_EN: round half up before truncation instead of plain floor
module fir_mac_sched #(
    parameter int NB_DATA   = 8,
    parameter int NBF_DATA  = 6,
    parameter int NB_COEFF  = 8,
    parameter int NBF_COEFF = 7,
    parameter int NTAP      = 6,
    parameter int NB_OUT    = 8,
    parameter int NBF_OUT   = 6
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    fir_mac_sched_if.slave bus
);
    localparam int PTR_W   = $clog2(NTAP);
    localparam int NB_PROD = NB_DATA + NB_COEFF;
    localparam int NB_ACC  = NB_PROD + $clog2(NTAP);
    localparam int NBF_ACC = NBF_DATA + NBF_COEFF;
    localparam int SHIFT   = NBF_ACC - NBF_OUT;
    localparam int NB_SUM  = NB_ACC + 1;

    localparam logic [PTR_W-1:0]         LAST_TAP = PTR_W'(NTAP - 1);
    localparam logic signed [NB_SUM-1:0] OUT_MAX  = NB_SUM'((1 << (NB_OUT - 1)) - 1);
    localparam logic signed [NB_SUM-1:0] OUT_MIN  = NB_SUM'(-(1 << (NB_OUT - 1)));
`ifdef FIR_SCHED_ROUND_EN
    localparam logic signed [NB_SUM-1:0] RND_BIAS = NB_SUM'(1 << (SHIFT - 1));
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t                   state_q, state_d;
    logic [NB_DATA-1:0]       dline_q [NTAP];
    logic [NB_DATA-1:0]       dline_d [NTAP];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         tap_q, tap_d;
    logic signed [NB_ACC-1:0] acc_q, acc_d;
    logic [NTAP*NB_COEFF-1:0] coeff_q, coeff_d;
    logic [NB_OUT-1:0]        o_data_q, o_data_d;
    logic                     o_valid_q, o_valid_d;
    logic                     o_sat_q, o_sat_d;
    logic                     o_ready_q, o_ready_d;
    logic                     o_busy_q, o_busy_d;

    logic [PTR_W-1:0]          rd_idx;
    logic signed [NB_DATA-1:0] x_sel;
    logic signed [NB_COEFF-1:0] h_sel;
    logic signed [NB_PROD-1:0] prod;
    logic signed [NB_ACC-1:0]  prod_ext;
    logic signed [NB_ACC-1:0]  acc_sum;
    logic signed [NB_SUM-1:0]  rnd_sum;
    logic signed [NB_SUM-1:0]  trunc;
    logic [NB_OUT-1:0]         sat_data;
    logic                      sat_flag;

    // Tap k reads the sample k acceptances back; wr_ptr still points at the newest one.
    always_comb begin
        rd_idx   = (wr_ptr_q >= tap_q) ? (wr_ptr_q - tap_q)
                                       : (wr_ptr_q + PTR_W'(NTAP) - tap_q);
        x_sel    = dline_q[rd_idx];
        h_sel    = coeff_q[tap_q*NB_COEFF +: NB_COEFF];
        prod     = x_sel * h_sel;
        prod_ext = {{(NB_ACC-NB_PROD){prod[NB_PROD-1]}}, prod};
        acc_sum  = acc_q + prod_ext;
`ifdef FIR_SCHED_ROUND_EN
        rnd_sum  = {acc_sum[NB_ACC-1], acc_sum} + RND_BIAS;
`else
        rnd_sum  = {acc_sum[NB_ACC-1], acc_sum};
`endif
        trunc    = rnd_sum >>> SHIFT;
        sat_flag = 1'b1;
        if (trunc > OUT_MAX) begin
            sat_data = OUT_MAX[NB_OUT-1:0];
        end else if (trunc < OUT_MIN) begin
            sat_data = OUT_MIN[NB_OUT-1:0];
        end else begin
            sat_data = trunc[NB_OUT-1:0];
            sat_flag = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        dline_d   = dline_q;
        wr_ptr_d  = wr_ptr_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        coeff_d   = coeff_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        o_sat_d   = o_sat_q;
        o_ready_d = o_ready_q;
        o_busy_d  = o_busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && o_ready_q) begin
                    dline_d[wr_ptr_q] = bus.i_data;
                    coeff_d           = bus.i_coeff;
                    acc_d             = '0;
                    tap_d             = '0;
                    o_ready_d         = 1'b0;
                    o_busy_d          = 1'b1;
                    state_d           = ST_MAC;
                end
            end
            ST_MAC: begin
                if (tap_q == LAST_TAP) begin
                    o_data_d  = sat_data;
                    o_sat_d   = sat_flag;
                    o_valid_d = 1'b1;
                    wr_ptr_d  = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    acc_d = acc_sum;
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    o_valid_d = 1'b0;
                    o_ready_d = 1'b1;
                    o_busy_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NTAP; i++) dline_q[i] <= '0;
            wr_ptr_q  <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            coeff_q   <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_sat_q   <= 1'b0;
            o_ready_q <= 1'b1;
            o_busy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dline_q   <= dline_d;
            wr_ptr_q  <= wr_ptr_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            coeff_q   <= coeff_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_sat_q   <= o_sat_d;
            o_ready_q <= o_ready_d;
            o_busy_q  <= o_busy_d;
        end
    end

    assign bus.o_ready = o_ready_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = o_sat_q;
    assign bus.o_busy  = o_busy_q;
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb/tb_fir_mac_sched.sv - directed bench for fir_mac_sched with a sum-of-products reference
module tb_fir_mac_sched;
    localparam int NB_DATA = 8, NBF_DATA = 6, NB_COEFF = 8, NBF_COEFF = 7;
    localparam int NTAP = 6, NB_OUT = 8, NBF_OUT = 6;
    localparam int SH = NBF_DATA + NBF_COEFF - NBF_OUT;
    localparam int OMAX = (1 << (NB_OUT - 1)) - 1;
    localparam int OMIN = -(1 << (NB_OUT - 1));
    localparam logic [NTAP*NB_COEFF-1:0] H_IMP = {8'hE0, 8'hF0, 8'h40, 8'h30, 8'h20, 8'h10};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fir_mac_sched_if #(.NB_DATA(NB_DATA), .NB_COEFF(NB_COEFF), .NTAP(NTAP), .NB_OUT(NB_OUT)) bus ();

    fir_mac_sched #(
        .NB_DATA(NB_DATA), .NBF_DATA(NBF_DATA), .NB_COEFF(NB_COEFF), .NBF_COEFF(NBF_COEFF),
        .NTAP(NTAP), .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [NB_OUT-1:0] data;
        logic              sat;
        int                due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    logic [NB_OUT-1:0] out_log[$];
    logic sat_log[$];
    int   acc_log[$];
    int   hist[NTAP];
    logic prev_v = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: y = sat(floor(sum_k x[k]*h[k] / 2^SH)) on the sample history.
    function automatic exp_t model(input logic [NTAP*NB_COEFF-1:0] cw, input int due);
        exp_t e;
        int   acc = 0;
        int   t;
        for (int k = 0; k < NTAP; k++) acc += hist[k] * int'($signed(cw[k*NB_COEFF +: NB_COEFF]));
`ifdef FIR_SCHED_ROUND_EN
        acc += 1 << (SH - 1);
`endif
        t = acc >>> SH;
        e.sat = 1'b1;
        if (t > OMAX)      e.data = NB_OUT'(OMAX);
        else if (t < OMIN) e.data = NB_OUT'(OMIN);
        else begin
            e.data = NB_OUT'(t);
            e.sat  = 1'b0;
        end
        e.due = due;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < NTAP; i++) hist[i] = 0;
            prev_v = 1'b0;
        end else begin
            chk("o_ready", int'(bus.o_ready), int'(exp_q.size() == 0));
            chk("o_busy", int'(bus.o_busy), int'(exp_q.size() != 0));
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("o_data", int'(bus.o_data), int'(exp_q[0].data));
                    chk("o_sat", int'(bus.o_sat), int'(exp_q[0].sat));
                    if (!prev_v) chk("latency", cyc, exp_q[0].due);
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                chk("output_timeout", 0, 1);
                void'(exp_q.pop_front());
            end
            prev_v = bus.o_valid;
            if (bus.o_valid && bus.i_ready && exp_q.size() != 0) begin
                out_log.push_back(bus.o_data);
                sat_log.push_back(bus.o_sat);
                void'(exp_q.pop_front());
            end
            if (bus.i_valid && bus.o_ready) begin
                for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'($signed(bus.i_data));
                exp_q.push_back(model(bus.i_coeff, cyc + 1 + NTAP));
                acc_log.push_back(cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        out_log.delete();
        sat_log.delete();
        acc_log.delete();
    endtask

    task automatic send(input logic [NB_DATA-1:0] d);
        int n    = 0;
        bit done = 1'b0;
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            if (bus.o_ready) done = 1'b1;
            n++;
        end
        if (!done) chk("send_timeout", 0, 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.o_ready) done = 1'b1;
            n++;
        end
        if (!done) chk("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] d, input logic s);
        if (out_log.size() > idx) begin
            chk({name, "_data"}, int'(out_log[idx]), int'(d));
            chk({name, "_sat"}, int'(sat_log[idx]), int'(s));
        end else begin
            chk({name, "_missing"}, out_log.size(), idx + 1);
        end
    endtask

    task automatic run_impulse(input string name);
        logic [7:0] exp_imp [6];
        exp_imp = '{8'h08, 8'h10, 8'h18, 8'h20, 8'hF8, 8'hF0};
        bus.i_ready = 1'b1;
        bus.i_coeff = H_IMP;
        out_log.delete();
        sat_log.delete();
        send(8'h40);
        repeat (5) send(8'h00);
        wait_idle();
        for (int i = 0; i < 6; i++) check_log(name, i, exp_imp[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_coeff = '0;
        bus.i_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_o_valid", int'(bus.o_valid), 0);
        chk("rst_o_data", int'(bus.o_data), 0);
        chk("rst_o_sat", int'(bus.o_sat), 0);
        chk("rst_o_busy", int'(bus.o_busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_o_ready", int'(bus.o_ready), 1);

        run_impulse("impulse");

        do_reset();
        bus.i_coeff = {NTAP{8'h7F}};
        repeat (6) send(8'h7F);
        wait_idle();
        check_log("pos_first", 0, 8'h7E, 1'b0);
        check_log("pos_sat", 5, 8'h7F, 1'b1);

        do_reset();
        repeat (6) send(8'h80);
        wait_idle();
        check_log("neg_first", 0, 8'h81, 1'b0);
        check_log("neg_sat", 5, 8'h80, 1'b1);

        do_reset();
        bus.i_coeff = {{(NTAP-1){8'h00}}, 8'h01};
        send(8'h7F);
        wait_idle();
`ifdef FIR_SCHED_ROUND_EN
        check_log("round", 0, 8'h01, 1'b0);
`else
        check_log("trunc", 0, 8'h00, 1'b0);
`endif

        do_reset();
        bus.i_coeff = H_IMP;
        bus.i_ready = 1'b0;
        send(8'h40);
        begin
            int n = 0;
            while (!bus.o_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_seen", int'(bus.o_valid), 1);
        end
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h55;
        repeat (5) begin
            tick();
            chk("bp_o_valid", int'(bus.o_valid), 1);
            chk("bp_o_ready", int'(bus.o_ready), 0);
            chk("bp_o_data", int'(bus.o_data), 8'h08);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        chk("bp_ready_after", int'(bus.o_ready), 1);
        chk("bp_valid_after", int'(bus.o_valid), 0);
        send(8'h00);
        wait_idle();
        check_log("bp_out0", 0, 8'h08, 1'b0);
        check_log("bp_out1", 1, 8'h10, 1'b0);

        do_reset();
        bus.i_coeff = H_IMP;
        bus.i_ready = 1'b1;
        bus.i_data  = 8'h20;
        bus.i_valid = 1'b1;
        repeat (34) tick();
        bus.i_valid = 1'b0;
        wait_idle();
        chk("tput_accepts", int'(acc_log.size() >= 4), 1);
        for (int i = 1; i < acc_log.size(); i++) chk("tput_spacing", acc_log[i] - acc_log[i-1], NTAP + 2);
        check_log("tput_first", 0, 8'h04, 1'b0);

        do_reset();
        bus.i_coeff = H_IMP;
        send(8'h40);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", int'(bus.o_valid), 0);
        chk("midrst_o_busy", int'(bus.o_busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_impulse("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
